// File: rtl/tile_map_arbiter.sv
// tile_map_arbiter: arbitrates video, physics and write ports onto one
// single-port 300x3 tile RAM. Video has absolute priority. Physics and writes
// alternate via a last_served bit. Out-of-range coordinates never touch the
// RAM. Out-of-range reads return the solid tile.
// Optional build macro TILE_MAP_INIT_EN: after reset, fill the RAM with the
// default level map (300 writes) before ready rises.
module tile_map_arbiter (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vid_req,
    input  logic [3:0] vid_row,
    input  logic [4:0] vid_col,
    output logic       vid_valid,
    output logic [2:0] vid_data,
    input  logic       phys_req,
    input  logic [3:0] phys_row,
    input  logic [4:0] phys_col,
    output logic       phys_gnt,
    output logic       phys_valid,
    output logic [2:0] phys_data,
    input  logic       wr_req,
    input  logic [3:0] wr_row,
    input  logic [4:0] wr_col,
    input  logic [2:0] wr_data,
    output logic       wr_gnt,
    output logic [8:0] mem_addr,
    output logic       mem_we,
    output logic [2:0] mem_wdata,
    input  logic [2:0] mem_rdata,
    output logic       ready
);
    localparam logic [2:0] SOLID   = 3'b111;
    localparam logic       LS_PHYS = 1'b0;
    localparam logic       LS_WR   = 1'b1;

    typedef enum logic {INIT, RUN} state_t;

    state_t     state;
    logic       last_served;
    logic       active;
    logic       vid_sel;
    logic       phys_sel;
    logic       wr_sel;
    logic       vid_rd_p1;
    logic       vid_oor_p1;
    logic       phys_rd_p1;
    logic       phys_oor_p1;
`ifdef TILE_MAP_INIT_EN
    logic [3:0] init_row;
    logic [4:0] init_col;
`endif

    function automatic logic [8:0] tile_addr(input logic [3:0] row, input logic [4:0] col);
        return ({5'd0, row} * 9'd20) + {4'd0, col};
    endfunction

    function automatic logic in_range(input logic [3:0] row, input logic [4:0] col);
        return (row < 4'd15) && (col < 5'd20);
    endfunction

`ifdef TILE_MAP_INIT_EN
    function automatic logic [2:0] init_tile(input logic [3:0] row, input logic [4:0] col);
        if (row >= 4'd11) return SOLID;
        if ((row == 4'd10) && (col >= 5'd16)) return SOLID;
        if ((row == 4'd9) && ((col == 5'd17) || (col == 5'd18))) return SOLID;
        return 3'b000;
    endfunction
`endif

    // Grant selection and RAM port drive for the current cycle
    always_comb begin
        active    = ready && !Reset;
        vid_sel   = active && vid_req;
        phys_sel  = active && !vid_req && phys_req && (!wr_req || (last_served == LS_WR));
        wr_sel    = active && !vid_req && wr_req && (!phys_req || (last_served == LS_PHYS));
        mem_addr  = 9'd0;
        mem_we    = 1'b0;
        mem_wdata = 3'b000;
        if (vid_sel) begin
            if (in_range(vid_row, vid_col)) mem_addr = tile_addr(vid_row, vid_col);
        end else if (phys_sel) begin
            if (in_range(phys_row, phys_col)) mem_addr = tile_addr(phys_row, phys_col);
        end else if (wr_sel && in_range(wr_row, wr_col)) begin
            mem_addr  = tile_addr(wr_row, wr_col);
            mem_we    = 1'b1;
            mem_wdata = wr_data;
        end
`ifdef TILE_MAP_INIT_EN
        if (!Reset && (state == INIT)) begin
            mem_addr  = tile_addr(init_row, init_col);
            mem_we    = 1'b1;
            mem_wdata = init_tile(init_row, init_col);
        end
`endif
    end

    // Grant strobes and read results (RAM data lands one cycle after the grant)
    always_comb begin
        phys_gnt   = phys_sel;
        wr_gnt     = wr_sel;
        vid_valid  = vid_rd_p1 && !Reset;
        phys_valid = phys_rd_p1 && !Reset;
        vid_data   = vid_valid ? (vid_oor_p1 ? SOLID : mem_rdata) : 3'b000;
        phys_data  = phys_valid ? (phys_oor_p1 ? SOLID : mem_rdata) : 3'b000;
    end

    // Mode FSM, ready flag, round-robin pointer and init fill counters
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_served <= LS_WR;
`ifdef TILE_MAP_INIT_EN
            state       <= INIT;
            ready       <= 1'b0;
            init_row    <= 4'd0;
            init_col    <= 5'd0;
`else
            state       <= RUN;
            ready       <= 1'b1;
`endif
        end else begin
            if (phys_sel) last_served <= LS_PHYS;
            else if (wr_sel) last_served <= LS_WR;
            case (state)
                INIT: begin
`ifdef TILE_MAP_INIT_EN
                    if (init_col == 5'd19) begin
                        init_col <= 5'd0;
                        if (init_row == 4'd14) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            init_row <= init_row + 4'd1;
                        end
                    end else begin
                        init_col <= init_col + 5'd1;
                    end
`else
                    state <= RUN;
                    ready <= 1'b1;
`endif
                end
                RUN: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Stage p1: read-in-flight flags (aborted by reset)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vid_rd_p1  <= 1'b0;
            phys_rd_p1 <= 1'b0;
        end else begin
            vid_rd_p1  <= vid_sel;
            phys_rd_p1 <= phys_sel;
        end
    end

    // Stage p1: out-of-range markers travelling with the read flags
    always_ff @(posedge Clk) begin
        vid_oor_p1  <= !in_range(vid_row, vid_col);
        phys_oor_p1 <= !in_range(phys_row, phys_col);
    end
endmodule

// File: tb/tb_tile_map_arbiter.sv
// tb_tile_map_arbiter: directed checks of tile_map_arbiter against a
// behavioural single-port RAM preloaded with ram[i] = i mod 8.
module tb_tile_map_arbiter;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       vid_req, phys_req, wr_req;
    logic [3:0] vid_row, phys_row, wr_row;
    logic [4:0] vid_col, phys_col, wr_col;
    logic [2:0] wr_data;
    logic       vid_valid, phys_valid, phys_gnt, wr_gnt, mem_we, ready;
    logic [2:0] vid_data, phys_data, mem_wdata;
    logic [2:0] mem_rdata = 3'b000;
    logic [8:0] mem_addr;
    logic       preload;
    logic [2:0] ram [0:299];
    int         compared = 0;
    int         mismatched = 0;

    tile_map_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .vid_req(vid_req), .vid_row(vid_row), .vid_col(vid_col),
        .vid_valid(vid_valid), .vid_data(vid_data),
        .phys_req(phys_req), .phys_row(phys_row), .phys_col(phys_col),
        .phys_gnt(phys_gnt), .phys_valid(phys_valid), .phys_data(phys_data),
        .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .wr_gnt(wr_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .ready(ready)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mem_addr < 9'd300) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end else begin
            mem_rdata <= 3'b000;
        end
        if (preload) begin
            for (int i = 0; i < 300; i++) ram[i] <= 3'(i);
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with every requester active
        Reset = 1'b1; preload = 1'b1;
        vid_req = 1'b1; vid_row = 4'd0; vid_col = 5'd3;
        phys_req = 1'b1; phys_row = 4'd0; phys_col = 5'd1;
        wr_req = 1'b1; wr_row = 4'd0; wr_col = 5'd2; wr_data = 3'd4;
        tick; preload = 1'b0; tick; tick;
        #2;
        check("rst_phys_gnt", 16'(phys_gnt), 16'd0);
        check("rst_wr_gnt", 16'(wr_gnt), 16'd0);
        check("rst_mem_we", 16'(mem_we), 16'd0);
        check("rst_vid_valid", 16'(vid_valid), 16'd0);
        check("rst_phys_valid", 16'(phys_valid), 16'd0);
        check("rst_vid_data", 16'(vid_data), 16'd0);
        check("rst_phys_data", 16'(phys_data), 16'd0);

        // Release reset
        tick; Reset = 1'b0; vid_req = 1'b0; phys_req = 1'b0; wr_req = 1'b0;
        #2;
        check("rel_vid_valid", 16'(vid_valid), 16'd0);
        check("rel_phys_valid", 16'(phys_valid), 16'd0);
`ifdef TILE_MAP_INIT_EN
        check("init_ready_low", 16'(ready), 16'd0);
        for (int i = 0; i <= 120; i++) begin
            check("init_addr_a", 16'(mem_addr), 16'(i));
            check("init_we_a", 16'(mem_we), 16'd1);
            if (i != 120) begin tick; #2; end
        end
        Reset = 1'b1;
        tick; Reset = 1'b0;
        #2;
        check("init_restart_addr", 16'(mem_addr), 16'd0);
        check("init_restart_ready", 16'(ready), 16'd0);
        for (int i = 0; i < 300; i++) begin
            check("init_addr", 16'(mem_addr), 16'(i));
            check("init_we", 16'(mem_we), 16'd1);
            if (i == 215) check("init_data_215", 16'(mem_wdata), 16'd0);
            if (i == 216) check("init_data_216", 16'(mem_wdata), 16'd7);
            if (i == 170) check("init_data_170", 16'(mem_wdata), 16'd0);
            if (i == 197) check("init_data_197", 16'(mem_wdata), 16'd7);
            if (i == 199) check("init_data_199", 16'(mem_wdata), 16'd0);
            if (i == 220) check("init_data_220", 16'(mem_wdata), 16'd7);
            if (i == 299) check("init_ready_last", 16'(ready), 16'd0);
            tick; #2;
        end
        check("init_ready_301", 16'(ready), 16'd1);
        check("init_done_we", 16'(mem_we), 16'd0);
        preload = 1'b1; tick; preload = 1'b0;
        #2;
`else
        check("rel_ready", 16'(ready), 16'd1);
`endif

        // Video read row 3 col 5 -> address 65, data 65 mod 8 = 1
        tick; vid_req = 1'b1; vid_row = 4'd3; vid_col = 5'd5;
        #2;
        check("vid_addr", 16'(mem_addr), 16'd65);
        check("vid_we", 16'(mem_we), 16'd0);
        tick; vid_req = 1'b0;
        #2;
        check("vid_valid", 16'(vid_valid), 16'd1);
        check("vid_data", 16'(vid_data), 16'd1);
        check("vid_no_phys_valid", 16'(phys_valid), 16'd0);

        // Out-of-range physics read then out-of-range write
        tick; phys_req = 1'b1; phys_row = 4'd15; phys_col = 5'd0;
        #2;
        check("oor_phys_gnt", 16'(phys_gnt), 16'd1);
        check("oor_phys_we", 16'(mem_we), 16'd0);
        check("oor_phys_addr", 16'(mem_addr), 16'd0);
        tick; phys_req = 1'b0; wr_req = 1'b1; wr_row = 4'd2; wr_col = 5'd20; wr_data = 3'd5;
        #2;
        check("oor_phys_valid", 16'(phys_valid), 16'd1);
        check("oor_phys_data", 16'(phys_data), 16'd7);
        check("oor_wr_gnt", 16'(wr_gnt), 16'd1);
        check("oor_wr_we", 16'(mem_we), 16'd0);

        // Both held, wr served last -> phys, wr, phys, wr
        tick; phys_req = 1'b1; phys_row = 4'd0; phys_col = 5'd1;
        wr_req = 1'b1; wr_row = 4'd0; wr_col = 5'd2; wr_data = 3'd3;
        #2;
        check("rr1_phys_gnt", 16'(phys_gnt), 16'd1);
        check("rr1_wr_gnt", 16'(wr_gnt), 16'd0);
        check("rr1_addr", 16'(mem_addr), 16'd1);
        tick; #2;
        check("rr2_wr_gnt", 16'(wr_gnt), 16'd1);
        check("rr2_phys_gnt", 16'(phys_gnt), 16'd0);
        check("rr2_we", 16'(mem_we), 16'd1);
        check("rr2_addr", 16'(mem_addr), 16'd2);
        check("rr2_wdata", 16'(mem_wdata), 16'd3);
        check("rr2_phys_valid", 16'(phys_valid), 16'd1);
        check("rr2_phys_data", 16'(phys_data), 16'd1);
        tick; #2;
        check("rr3_phys_gnt", 16'(phys_gnt), 16'd1);
        tick; #2;
        check("rr4_wr_gnt", 16'(wr_gnt), 16'd1);

        // Video held 10 cycles with phys and wr pending
        tick; vid_req = 1'b1; vid_row = 4'd0; vid_col = 5'd5; phys_col = 5'd4;
        for (int k = 0; k < 10; k++) begin
            #2;
            check("vid_hold_phys_gnt", 16'(phys_gnt), 16'd0);
            check("vid_hold_wr_gnt", 16'(wr_gnt), 16'd0);
            if (k > 0) check("vid_hold_valid", 16'(vid_valid), 16'd1);
            tick;
        end
        vid_req = 1'b0;
        #2;
        check("vid_drop_phys_gnt", 16'(phys_gnt), 16'd1);
        check("vid_drop_wr_gnt", 16'(wr_gnt), 16'd0);
        check("vid_drop_data", 16'(vid_data), 16'd5);
        tick; phys_req = 1'b0;
        #2;
        check("after_wr_gnt", 16'(wr_gnt), 16'd1);
        check("after_phys_data", 16'(phys_data), 16'd4);

        // In-range write then read back
        tick; wr_row = 4'd1; wr_col = 5'd2; wr_data = 3'd6;
        #2;
        check("wr_gnt", 16'(wr_gnt), 16'd1);
        check("wr_we", 16'(mem_we), 16'd1);
        check("wr_addr", 16'(mem_addr), 16'd22);
        check("wr_wdata", 16'(mem_wdata), 16'd6);
        tick; wr_req = 1'b0; phys_req = 1'b1; phys_row = 4'd1; phys_col = 5'd2;
        #2;
        check("rb_phys_gnt", 16'(phys_gnt), 16'd1);
        check("rb_addr", 16'(mem_addr), 16'd22);
        tick; phys_req = 1'b0;
        #2;
        check("rb_valid", 16'(phys_valid), 16'd1);
        check("rb_data", 16'(phys_data), 16'd6);
        check("idle_we", 16'(mem_we), 16'd0);
        check("idle_addr", 16'(mem_addr), 16'd0);

        // Reset one cycle after a video read grant
        tick; vid_req = 1'b1; vid_row = 4'd0; vid_col = 5'd3;
        #2;
        check("abort_addr", 16'(mem_addr), 16'd3);
        tick; vid_req = 1'b0; Reset = 1'b1;
        #2;
        check("abort_valid_rst", 16'(vid_valid), 16'd0);
        check("abort_data_rst", 16'(vid_data), 16'd0);
        tick; Reset = 1'b0;
        #2;
        check("abort_valid_after", 16'(vid_valid), 16'd0);
`ifdef TILE_MAP_INIT_EN
        check("reinit_ready_low", 16'(ready), 16'd0);
        repeat (300) tick;
        #2;
`endif
        check("reinit_ready", 16'(ready), 16'd1);

        // First tie after reset goes to phys
        tick; phys_req = 1'b1; phys_row = 4'd0; phys_col = 5'd1;
        wr_req = 1'b1; wr_row = 4'd0; wr_col = 5'd2; wr_data = 3'd2;
        #2;
        check("tie_phys_gnt", 16'(phys_gnt), 16'd1);
        check("tie_wr_gnt", 16'(wr_gnt), 16'd0);
        tick; #2;
        check("tie2_wr_gnt", 16'(wr_gnt), 16'd1);
        tick; phys_req = 1'b0; wr_req = 1'b0;
        #2;
        check("end_idle_we", 16'(mem_we), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
